// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared FSM states, settle length and select-width helper for the ring oscillator meter
package ringosc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;
  localparam int SETTLE_CYCLES = 4;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ringosc_chain.sv
// ringosc_chain: odd-length ring of NOR_2 cells; en low breaks the loop and parks the output low
module ringosc_chain #(
  parameter int STAGES = 3
)(
  input  logic en,
  output logic out
);
  logic [STAGES-1:0] w_n;
  assign w_n[0] = ~(w_n[STAGES-1] | ~en);
  for (genvar i = 1; i < STAGES; i++) begin : g_st
    assign w_n[i] = ~(w_n[i-1] | w_n[i-1]);
  end
  assign out = w_n[STAGES-1];
endmodule

// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: ring oscillator bank with a windowed, synchronised rising-edge counter
module ringosc_freq_meter
  import ringosc_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 3,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16,
  localparam int SW      = sel_w(CHANNELS)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SW-1:0]       sel,
  input  logic [WIN_W-1:0]    window,
  input  logic                tst_en,
  input  logic                tst_in,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic [CHANNELS-1:0] ring_out
);
  state_t              r_state, w_nxt;
  logic [SW-1:0]       r_sel;
  logic [WIN_W-1:0]    r_win, r_tmr;
  logic                r_tst, r_s1, r_s2, r_s3, r_ovf;
  logic [CNT_W-1:0]    r_count;
  logic [CHANNELS-1:0] w_ring_en;
  logic                w_run, w_src, w_rise, w_tmr0, w_acc;
  assign w_run  = (r_state == S_SETTLE) || (r_state == S_COUNT);
  assign w_tmr0 = (r_tmr == '0);
  assign w_acc  = (r_state == S_IDLE) && start;
  assign w_rise = r_s2 & ~r_s3;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_ring_en[k] = w_run && !r_tst && (32'(r_sel) == k);
    ringosc_chain #(.STAGES(STAGES)) u_chain (.en(w_ring_en[k]), .out(ring_out[k]));
  end
  // an out-of-range select reads as a silent source rather than an X
  assign w_src = r_tst ? tst_in : (32'(r_sel) < CHANNELS) ? ring_out[r_sel] : 1'b0;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = start ? S_SETTLE : S_IDLE;
      S_SETTLE: if (w_tmr0) w_nxt = (r_win == '0) ? S_DONE : S_COUNT;
      S_COUNT:  if (w_tmr0) w_nxt = S_DONE;
      default:  w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_win   <= '0;
      r_tmr   <= '0;
      r_tst   <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, w_src};
      if (w_acc) begin
        r_sel   <= sel;
        r_win   <= window;
        r_tst   <= tst_en;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_tmr   <= WIN_W'(SETTLE_CYCLES - 1);
      end else if (r_state == S_SETTLE && w_tmr0) begin
        r_tmr <= r_win - 1'b1;
      end else if (w_run && !w_tmr0) begin
        r_tmr <= r_tmr - 1'b1;
      end
      if (r_state == S_COUNT && w_rise) begin
        if (&r_count) r_ovf <= 1'b1;
        else r_count <= r_count + 1'b1;
      end
    end
  end
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign count    = r_count;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_ringosc_freq_meter.sv
// tb_ringosc_freq_meter: randomized checks of two meter builds against a per-cycle edge-count model
module tb_ringosc_freq_meter;
  localparam int TVN = 8192;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tst_en = 1'b0, tst_in = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] window = '0;
  logic busy, done, ovf, busy_s, done_s, ovf_s;
  logic [15:0] count;
  logic [3:0]  count_s, ring_out;
  logic [2:0]  ring_out_s;
  int total = 0, bad = 0, cyc = 0, mode = 0, per = 4;
  bit lvl = 1'b0;
  logic tv [0:TVN-1];
  always #5 clk = ~clk;
  ringosc_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .window(window), .tst_en(tst_en),
    .tst_in(tst_in), .busy(busy), .done(done), .count(count), .overflow(ovf), .ring_out(ring_out));
  ringosc_freq_meter #(.CHANNELS(3), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .window(window), .tst_en(tst_en),
    .tst_in(tst_in), .busy(busy_s), .done(done_s), .count(count_s), .overflow(ovf_s),
    .ring_out(ring_out_s));
  // tv[c] is the tst_in level held during cycle c (the cycle starting at posedge number c)
  initial for (int i = 0; i < TVN; i++) tv[i] = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    tst_in = (mode == 0) ? lvl : (mode == 1) ? ((cyc % per) < per / 2) : 1'($urandom_range(0, 1));
    if (cyc < TVN) tv[cyc] = tst_in;
  end
  function automatic int rises(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++)
      if (c >= 1 && c < TVN && tv[c] && !tv[c-1]) n++;
    return n;
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  // a rise seen by the counter in cycle j reflects the input of cycle j-2
  task automatic meas(input int s, input int w, input bit te, input bit poke);
    int t, c, n, e;
    @(posedge clk); #1;
    sel = 2'(s); window = 16'(w); tst_en = te; start = 1'b1; t = cyc;
    for (int j = 1; j <= w + 13; j++) begin
      @(posedge clk); #1;
      c = cyc;
      start = poke && (c == t + 2);
      if (poke && c == t + 2) window = 16'd3;
      if (c == t + 1) begin
        chk("clear_count", count, 0);
        chk("clear_ovf", ovf, 0);
        chk("clear_count_s", count_s, 0);
        chk("clear_ovf_s", ovf_s, 0);
      end
      chk("busy", busy, (c >= t + 1) && (c <= t + 5 + w));
      chk("done", done, c == t + 5 + w);
      chk("done_s", done_s, c == t + 5 + w);
      e = (!te && c >= t + 1 && c <= t + 4 + w) ? (1 << s) : 0;
      chk("ring_en", dut.w_ring_en, e);
      chk("ring_en_s", dut_s.w_ring_en, (s < 3) ? e : 0);
      if (c == t + 5 + w) begin
        n = te ? rises(t + 3, t + 2 + w) : 0;
        chk("count", count, (n > 65535) ? 65535 : n);
        chk("ovf", ovf, n > 65535);
        chk("count_s", count_s, (n > 15) ? 15 : n);
        chk("ovf_s", ovf_s, n > 15);
      end
    end
    start = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_en", dut.w_ring_en, 0);
    chk("rst_count_s", count_s, 0);
    rst = 1'b0;
    force dut.g_ch[2].u_chain.w_n = '0;
    force dut.g_ch[3].u_chain.w_n = '0;
    force dut_s.g_ch[2].u_chain.w_n = '0;
    mode = 1; per = 4;
    meas(0, 100, 1'b1, 1'b0);
    chk("p4_count", count, 25);
    chk("p4_ovf", ovf, 0);
    chk("sat_count", count_s, 15);
    chk("sat_ovf", ovf_s, 1);
    meas(1, 20, 1'b1, 1'b0);
    mode = 0; lvl = 1'b1;
    repeat (5) @(posedge clk);
    meas(0, 50, 1'b1, 1'b0);
    chk("const_count", count, 0);
    mode = 1; per = 2;
    meas(0, 64, 1'b1, 1'b0);
    chk("p2_count", count, 32);
    meas(0, 0, 1'b1, 1'b1);
    chk("zero_count", count, 0);
    per = 4;
    meas(3, 30, 1'b1, 1'b1);
    @(posedge clk); #1;
    sel = 2'd0; window = 16'd100; tst_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_en", dut.w_ring_en, 0);
    rst = 1'b0;
    meas(0, 40, 1'b1, 1'b0);
    chk("after_rst_count", count, 10);
    meas(2, 20, 1'b0, 1'b0);
    meas(3, 15, 1'b0, 1'b0);
    chk("oor_count_s", count_s, 0);
    mode = 2;
    for (int i = 0; i < 8; i++)
      meas(int'($urandom_range(0, 3)), int'($urandom_range(0, 80)), 1'b1, 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ringosc_freq_meter.md
# ringosc_freq_meter

Parametrised bank of enable-gated NOR ring oscillators with an on-chip frequency meter. One selected ring runs for a programmed window of system-clock cycles; its rising edges are synchronised and counted, and the count is returned with a done pulse. This is the successor to the single fixed 3-stage oscillator. It sits between the tile's control inputs and its result outputs. It also provides a test-injection path so the counter can be verified without real oscillation.

## Interface
Parameters:
- CHANNELS, 4: number of independent ring oscillators; ≥1.
- STAGES, 3: NOR-inverter stages per ring; odd, ≥3.
- CNT_W, 16: edge-counter width.
- WIN_W, 16: measurement-window width, in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; sampled in IDLE only.
- sel  in  $clog2(CHANNELS) (min 1)  ring to measure; latched on start.
- window  in  WIN_W  counting window length; latched on start.
- tst_en  in  1  1 = count tst_in instead of the selected ring; latched on start.
- tst_in  in  1  injected test waveform (asynchronous allowed).
- busy  out  1  high from the cycle after start acceptance through the DONE state.
- done  out  1  one-cycle pulse; count/overflow valid from this cycle.
- count  out  CNT_W  rising edges seen in the window, saturating.
- overflow  out  1  count saturated during the last measurement.
- ring_out  out  CHANNELS  raw ring outputs, for pad/debug only.

## Operation
- **Ring enables.** Ring k's enable is 1 only in SETTLE/COUNT when sel_q==k and tst_en_q==0. All rings are otherwise held stopped, with output forced low by the enable.
- **Source mux.** src = tst_en_q ? tst_in : ring_out[sel_q]. If sel_q ≥ CHANNELS, src = 0.
- **Synchroniser and edge detect.** src passes through a 2-flop synchroniser (s1, s2), then an edge register s3. rise = s2 & ~s3.
- **FSM states.** IDLE, SETTLE, COUNT, DONE.
  - IDLE: on start, latch sel/window/tst_en, clear count and overflow, go to SETTLE.
  - SETTLE: exactly SETTLE_CYCLES=4 cycles; flushes the synchroniser. rise is ignored. Exit to COUNT, or to DONE if window_q==0.
  - COUNT: window_q cycles. On each cycle with rise, count increments. If count is at 2^CNT_W−1, count holds and overflow is set instead.
  - DONE: one cycle; done=1, then IDLE.
- **Ignored inputs.** start while not in IDLE is ignored; no queuing. start and rst in the same cycle: rst wins.
- **Result hold.** count/overflow hold their value after DONE until the next accepted start clears them.
- **Reset mid-operation.** Any state returns to IDLE next cycle, with all enables off and outputs at reset values.
- **Measurable range.** Only src frequencies below f_clk/2 are measured correctly. Faster rings alias, which is accepted and documented.

## Timing
- Reset values: busy=0, done=0, count=0, overflow=0, all ring enables 0, FSM=IDLE, s1/s2/s3=0.
- Start accepted in cycle T:
  - SETTLE occupies T+1..T+4.
  - COUNT occupies T+5..T+4+W.
  - DONE (done=1) occurs at T+5+W. count is final in that cycle.
  - busy=1 over T+1..T+5+W.
- With W=0, DONE is at T+5 and count=0.
- Earliest next start accepted: T+6+W.
- Edge-to-count latency: src rise to count increment is 3 cycles. Edges reaching s2 after the last COUNT cycle are not counted.

## Structure
- Package ringosc_pkg holds:
  - the FSM state enum;
  - SETTLE_CYCLES=4;
  - a helper function for the sel width (max(1, clog2)).
- Sub-module ringosc_chain (parameter STAGES; ports en, out) is instantiated CHANNELS times. It is built from NOR_2 cells, with the feedback gated by en.
- Top-level contents: source mux, synchroniser, FSM, window down-counter, saturating edge counter.

## Test plan
- **Period-4 count.** Reset, tst_en=1, tst_in square wave period 4 clk, window=100, start → done at T+105, count=25, overflow=0.
- **Constant input.** tst_in held at 1, window=50 → count=0. tst_in toggling every cycle (period 2), window=64 → count=32.
- **Saturation.** CNT_W=4 build, tst_in period 4, window=100 → count=15, overflow=1; next start clears both to 0 at T+1.
- **Zero window / busy start.** window=0 → done at T+5, count=0. A second start pulsed during busy → ignored, exactly one done seen.
- **Reset mid-COUNT.** Assert rst mid-COUNT → next cycle busy=0, count=0, enables=0. A fresh start then completes normally with the correct count.
- **Enables and select.** tst_en=0 with sel=2: only ring_en[2] high during SETTLE/COUNT, all low in IDLE/DONE. Out-of-range sel (CHANNELS=3, sel=3) → count=0.
